// File: rtl/context_cache_mq_if.sv
// Bundle of all non-clock signals of context_cache_mq.
// master: drives ins/req/ret/wake requests; slave: returns ready/ack/rsp/status.
interface context_cache_mq_if #(
   parameter int SLOTS = 16,
   parameter int CTX_W = 256,
   parameter int PRIO  = 2
);
   localparam int ID_W = $clog2(SLOTS);
   localparam int PW   = (PRIO > 1) ? $clog2(PRIO) : 1;
   localparam int CW   = ID_W + 1;

   logic                ins_valid;
   logic                ins_ready;
   logic [CTX_W-1:0]    ins_ctx;
   logic [PW-1:0]       ins_prio;
   logic                ins_sleep;
   logic                ins_ack;
   logic [ID_W-1:0]     ins_id;

   logic                req;
   logic                rsp_valid;
   logic [ID_W-1:0]     rsp_id;
   logic [CTX_W-1:0]    rsp_ctx;
   logic [PW-1:0]       rsp_prio;

   logic                ret_valid;
   logic [ID_W-1:0]     ret_id;
   logic [CTX_W-1:0]    ret_ctx;
   logic [1:0]          ret_op;
   logic [PW-1:0]       ret_prio;

   logic                wake_valid;
   logic                wake_ready;
   logic [ID_W-1:0]     wake_id;

   logic [CW-1:0]       free_count;
   logic [PRIO*CW-1:0]  q_count;
   logic                err;

   modport master (
      output ins_valid, ins_ctx, ins_prio, ins_sleep,
      output req,
      output ret_valid, ret_id, ret_ctx, ret_op, ret_prio,
      output wake_valid, wake_id,
      input  ins_ready, ins_ack, ins_id,
      input  rsp_valid, rsp_id, rsp_ctx, rsp_prio,
      input  wake_ready, free_count, q_count, err
   );

   modport slave (
      input  ins_valid, ins_ctx, ins_prio, ins_sleep,
      input  req,
      input  ret_valid, ret_id, ret_ctx, ret_op, ret_prio,
      input  wake_valid, wake_id,
      output ins_ready, ins_ack, ins_id,
      output rsp_valid, rsp_id, rsp_ctx, rsp_prio,
      output wake_ready, free_count, q_count, err
   );
endinterface

// File: rtl/context_cache_mq.sv
// Thread-context store: free list + PRIO ring-buffer work queues, strict-priority dequeue.
// Ports: clk, rst (sync, active-high), bus (context_cache_mq_if.slave: ins/req/ret/wake/status).
module context_cache_mq #(
   parameter int SLOTS = 16,
   parameter int CTX_W = 256,
   parameter int PRIO  = 2
) (
   input logic               clk,
   input logic               rst,
   context_cache_mq_if.slave bus
);
   localparam int ID_W = $clog2(SLOTS);
   localparam int PW   = (PRIO > 1) ? $clog2(PRIO) : 1;
   localparam int CW   = ID_W + 1;

   typedef enum logic [1:0] {
      ST_FREE, ST_QUEUED, ST_EXEC, ST_SLEEP
   } st_e;

   st_e              status  [SLOTS];
   logic [PW-1:0]    sprio   [SLOTS];
   logic [CTX_W-1:0] ctx_mem [SLOTS];

   logic [ID_W-1:0]  fl_mem  [SLOTS];
   logic [ID_W-1:0]  fl_head;
   logic [ID_W-1:0]  fl_tail;
   logic [CW-1:0]    fl_cnt;

   logic [ID_W-1:0]  q_mem   [PRIO][SLOTS];
   logic [ID_W-1:0]  q_head  [PRIO];
   logic [ID_W-1:0]  q_tail  [PRIO];
   logic [CW-1:0]    q_cnt   [PRIO];

   logic             ack_q;
   logic [ID_W-1:0]  ack_id_q;
   logic             rsp_v_q;
   logic [ID_W-1:0]  rsp_id_q;
   logic [CTX_W-1:0] rsp_ctx_q;
   logic [PW-1:0]    rsp_prio_q;
   logic             err_q;

   logic             ret_ok;
   logic             ret_err;
   logic             wake_acc;
   logic             wake_ok;
   logic             wake_err;
   logic             ins_rdy;
   logic             ins_acc;
   logic             op_sleep;
   logic             op_del;
   logic             op_req;
   logic             fl_push;
   logic [ID_W-1:0]  new_id;

   logic             any_q;
   logic [PW-1:0]    sel_q;
   logic             pop;
   logic [ID_W-1:0]  pop_id;

   logic             push_en;
   logic [PW-1:0]    push_q;
   logic [ID_W-1:0]  push_id;

   function automatic logic [PW-1:0] clamp(input logic [PW-1:0] p);
      if (int'(p) >= PRIO) return PW'(PRIO - 1);
      return p;
   endfunction

   // ret always owns the single enqueue port; wake beats ins.
   assign ret_ok   = bus.ret_valid && (status[bus.ret_id] == ST_EXEC);
   assign ret_err  = bus.ret_valid && !ret_ok;
   assign wake_acc = bus.wake_valid && !bus.ret_valid;
   assign wake_ok  = wake_acc && (status[bus.wake_id] == ST_SLEEP);
   assign wake_err = wake_acc && !wake_ok;
   assign ins_rdy  = !bus.ret_valid && !bus.wake_valid
                     && (fl_cnt != '0);
   assign ins_acc  = bus.ins_valid && ins_rdy;

   // op 3 is reserved and behaves as requeue.
   assign op_sleep = (bus.ret_op == 2'd1);
   assign op_del   = (bus.ret_op == 2'd2);
   assign op_req   = !op_sleep && !op_del;
   assign fl_push  = ret_ok && op_del;
   assign new_id   = fl_mem[fl_head];

   // Lowest-index non-empty queue wins; counts are registered,
   // so a same-cycle push is not yet visible here.
   always_comb begin
      any_q = 1'b0;
      sel_q = '0;
      for (int i = PRIO - 1; i >= 0; i--) begin
         if (q_cnt[i] != '0) begin
            any_q = 1'b1;
            sel_q = PW'(i);
         end
      end
   end

   assign pop    = bus.req && any_q;
   assign pop_id = q_mem[sel_q][q_head[sel_q]];

   always_comb begin
      push_en = 1'b0;
      push_q  = '0;
      push_id = '0;
      if (ret_ok) begin
         if (op_req) begin
            push_en = 1'b1;
            push_q  = clamp(bus.ret_prio);
            push_id = bus.ret_id;
         end
      end else if (wake_ok) begin
         push_en = 1'b1;
         push_q  = sprio[bus.wake_id];
         push_id = bus.wake_id;
      end else if (ins_acc && !bus.ins_sleep) begin
         push_en = 1'b1;
         push_q  = clamp(bus.ins_prio);
         push_id = new_id;
      end
   end

   // Context RAM carries no reset; every slot is written before it is read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (ret_ok)
            ctx_mem[bus.ret_id] <= op_del ? '0 : bus.ret_ctx;
         else if (ins_acc)
            ctx_mem[new_id] <= bus.ins_ctx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SLOTS; i++) begin
            status[i] <= ST_FREE;
            sprio[i]  <= '0;
            fl_mem[i] <= ID_W'(i);
         end
         fl_head <= '0;
         fl_tail <= '0;
         fl_cnt  <= CW'(SLOTS);
         for (int q = 0; q < PRIO; q++) begin
            q_head[q] <= '0;
            q_tail[q] <= '0;
            q_cnt[q]  <= '0;
         end
         ack_q      <= 1'b0;
         ack_id_q   <= '0;
         rsp_v_q    <= 1'b0;
         rsp_id_q   <= '0;
         rsp_ctx_q  <= '0;
         rsp_prio_q <= '0;
         err_q      <= 1'b0;
      end else begin
         ack_q   <= ins_acc;
         rsp_v_q <= pop;
         err_q   <= ret_err || wake_err;

         if (pop) begin
            rsp_id_q       <= pop_id;
            rsp_ctx_q      <= ctx_mem[pop_id];
            rsp_prio_q     <= sel_q;
            status[pop_id] <= ST_EXEC;
         end

         if (ret_ok) begin
            if (op_del) begin
               status[bus.ret_id] <= ST_FREE;
               fl_mem[fl_tail]    <= bus.ret_id;
               fl_tail            <= fl_tail + 1'b1;
            end else begin
               status[bus.ret_id] <= op_sleep ? ST_SLEEP : ST_QUEUED;
               sprio[bus.ret_id]  <= clamp(bus.ret_prio);
            end
         end else if (wake_ok) begin
            status[bus.wake_id] <= ST_QUEUED;
         end else if (ins_acc) begin
            status[new_id] <= bus.ins_sleep ? ST_SLEEP : ST_QUEUED;
            sprio[new_id]  <= clamp(bus.ins_prio);
            fl_head        <= fl_head + 1'b1;
            ack_id_q       <= new_id;
         end

         if (fl_push)
            fl_cnt <= fl_cnt + 1'b1;
         else if (ins_acc)
            fl_cnt <= fl_cnt - 1'b1;

         if (push_en)
            q_mem[push_q][q_tail[push_q]] <= push_id;

         // Push and pop on one queue in a cycle leave the count unchanged.
         for (int q = 0; q < PRIO; q++) begin
            if (push_en && push_q == PW'(q))
               q_tail[q] <= q_tail[q] + 1'b1;
            if (pop && sel_q == PW'(q))
               q_head[q] <= q_head[q] + 1'b1;
            q_cnt[q] <= q_cnt[q]
                        + CW'(push_en && push_q == PW'(q))
                        - CW'(pop && sel_q == PW'(q));
         end
      end
   end

   assign bus.ins_ready  = ins_rdy;
   assign bus.wake_ready = !bus.ret_valid;
   assign bus.ins_ack    = ack_q;
   assign bus.ins_id     = ack_id_q;
   assign bus.rsp_valid  = rsp_v_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_ctx    = rsp_ctx_q;
   assign bus.rsp_prio   = rsp_prio_q;
   assign bus.free_count = fl_cnt;
   assign bus.err        = err_q;

   // Class 0 occupies the least-significant field.
   always_comb begin
      bus.q_count = '0;
      for (int q = 0; q < PRIO; q++)
         bus.q_count[q*CW +: CW] = q_cnt[q];
   end
endmodule

// File: doc/context_cache_mq.md
Name: context_cache_mq

Overview:
- Parametrised successor thread-context store for the LCISC execution engine.
- Holds up to SLOTS thread contexts with per-slot status.
- Free list and PRIO priority work queues are ring-buffer FIFOs; no shifting arrays.
- Serves the scheduler with strict-priority dequeue and accepts insert, disposition-return and wake-on-trigger traffic.

Parameters:
SLOTS, 16, number of thread slots (power of two, >=2)
CTX_W, 256, bits per thread context (data + instructions)
PRIO, 2, number of work-queue priority classes (queue 0 = highest)
ID_W, $clog2(SLOTS), thread id width (derived)
PW, max(1,$clog2(PRIO)), priority field width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ins_valid  in  1  insert new thread
ins_ready  out  1  insert accepted this cycle when ins_valid&ins_ready
ins_ctx  in  CTX_W  new context
ins_prio  in  PW  queue class
ins_sleep  in  1  1: create sleeping, 0: create queued
ins_ack  out  1  registered pulse, insert done
ins_id  out  ID_W  id assigned (valid with ins_ack)
req  in  1  scheduler requests a thread
rsp_valid  out  1  registered, response carries a thread
rsp_id  out  ID_W  dequeued id
rsp_ctx  out  CTX_W  dequeued context
rsp_prio  out  PW  class it came from
ret_valid  in  1  disposition returns executing thread
ret_id  in  ID_W  returning id
ret_ctx  in  CTX_W  updated context
ret_op  in  2  0 requeue, 1 sleep, 2 delete, 3 reserved (treated as requeue)
ret_prio  in  PW  class for requeue/sleep
wake_valid  in  1  trigger wakes sleeping thread
wake_ready  out  1  wake accepted
wake_id  in  ID_W  thread to wake
free_count  out  ID_W+1  registered free slots
q_count  out  PRIO*(ID_W+1)  registered per-class queue occupancy, class 0 in LSBs
err  out  1  registered pulse on illegal ret/wake

Behaviour:
- Slot state: status {FREE, QUEUED, EXEC, SLEEP}, stored prio, context RAM[SLOTS][CTX_W].
- Reset: status all FREE. Free list holds 0..SLOTS-1 in order (head=0). All queues empty. free_count=SLOTS, q_count=0. ins_ack, rsp_valid and err are 0; ins_id, rsp_id, rsp_ctx and rsp_prio are 0. Reset mid-operation discards all in-flight state; no pulse follows reset.
- Out-of-range prio (>=PRIO) clamps to PRIO-1.
- One enqueue port per cycle, arbitrated ret > wake > ins:
  - wake_ready = !ret_valid.
  - ins_ready = !ret_valid & !wake_valid & (free_count != 0).
- ret (every cycle it is valid):
  - Requires status[ret_id]==EXEC; otherwise ignore and pulse err next cycle.
  - Writes ret_ctx.
  - op0: status QUEUED, push ret_prio queue.
  - op1: status SLEEP, store ret_prio.
  - op2: status FREE, push id to free-list tail, context zeroed.
- wake (accepted):
  - Requires status SLEEP; else ignore and pulse err.
  - Sets QUEUED and pushes its stored prio queue.
- ins (accepted):
  - Pops free-list head, writes ctx/prio, status SLEEP if ins_sleep else QUEUED (push).
  - Next cycle ins_ack=1 and ins_id=popped id.
- req:
  - Picks the lowest-index non-empty queue, pops its head, sets status EXEC.
  - Next cycle rsp_valid=1 with id, ctx and prio.
  - All queues empty: rsp_valid=0 next cycle, no state change.
  - Dequeue is independent of the enqueue port. An entry enqueued in cycle N is poppable from cycle N+1 only.
  - Pop and push on the same queue in the same cycle are both honoured; occupancy is unchanged.
- Delete and insert never coincide, because ins is blocked while ret_valid.
- Occupancy never exceeds SLOTS per queue; no overflow path exists because each id is in at most one structure.
- free_count and q_count reflect state after the cycle's updates and are registered (1-cycle lag).

Test Plan:
- Reset, then insert 3 ctx (prio 1,0,1, sleep=0) -> ins_id 0,1,2; q_count = {q1=2, q0=1}; free_count=13.
- req x3 -> rsp_id 1 (prio0), then 0, then 2; 4th req -> rsp_valid=0.
- ret id0 op1 prio0, then wake id0 -> after wake q0=1; req returns id0 with returned ctx; wake id0 again while EXEC -> err pulse, no queue change.
- ret id2 op2 while ins_valid high -> ins_ready=0 that cycle; next insert gets id 3 (free list FIFO order); deleted id 2 is reissued only after ids 3..15.
- Insert 16 threads -> ins_ready=0, free_count=0; 17th ins_valid held with no ins_ack; delete one -> insert completes with the freed id.
- Insert 4 queued threads, pulse rst with req high -> next cycle rsp_valid=0, q_count=0, free_count=16; first insert gets id 0.
